// File: rtl/wb_arbiter_nm_if.sv
// Wishbone bus bundle for the N-master arbiter: master-facing ports plus the shared slave port.
// "slave" is the arbiter's view (it is the slave of every master); "master" is the driving side.
interface wb_arbiter_nm_if #(
  parameter int N_MASTERS = 4,
  parameter int AW        = 32,
  parameter int DW        = 32
);
  localparam int SW = DW / 8;

  logic [N_MASTERS-1:0]    m_cyc_i, m_stb_i, m_we_i;
  logic [N_MASTERS*SW-1:0] m_sel_i;
  logic [N_MASTERS*AW-1:0] m_adr_i;
  logic [N_MASTERS*DW-1:0] m_dat_i;
  logic [N_MASTERS-1:0]    m_ack_o, m_err_o;
  logic [DW-1:0]           m_dat_o;
  logic                    s_cyc_o, s_stb_o, s_we_o;
  logic [SW-1:0]           s_sel_o;
  logic [AW-1:0]           s_adr_o;
  logic [DW-1:0]           s_dat_o;
  logic                    s_ack_i;
  logic [DW-1:0]           s_dat_i;

  modport slave (
    input  m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i, s_ack_i, s_dat_i,
    output m_ack_o, m_err_o, m_dat_o, s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o
  );

  modport master (
    output m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i, s_ack_i, s_dat_i,
    input  m_ack_o, m_err_o, m_dat_o, s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o
  );
endinterface

// File: rtl/wb_arbiter_nm.sv
// N-master Wishbone arbiter: round-robin or fixed priority, ownership held for a whole cycle,
// registered grant driving the slave mux, and an ack timeout that returns a one-cycle error.
module wb_arbiter_nm #(
  parameter int N_MASTERS     = 4,
  parameter int AW            = 32,
  parameter int DW            = 32,
  parameter int PRIORITY_MODE = 0,
  parameter int TIMEOUT       = 255
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  wb_arbiter_nm_if.slave       bus,
  output logic [N_MASTERS-1:0] grant_o,
  output logic                 busy_o
);
  localparam int SW = DW / 8;
  localparam int OW = $clog2(N_MASTERS);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic {IDLE, OWN} state_e;

  state_e               state_q, state_d;
  logic [OW-1:0]        owner_q, owner_d, ptr_q, ptr_d, win;
  logic [N_MASTERS-1:0] grant_q, grant_d, err_q, err_d, req;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 free, timeout;

  function automatic logic [OW-1:0] nxt(input logic [OW-1:0] i);
    return (int'(i) == N_MASTERS - 1) ? '0 : i + 1'b1;
  endfunction

  assign req  = bus.m_cyc_i & bus.m_stb_i;
  assign free = (state_q == IDLE) || !bus.m_cyc_i[owner_q];
  assign timeout = (TIMEOUT > 0) && (state_q == OWN) && bus.s_stb_o && !bus.s_ack_i &&
                   (cnt_q == TO_LAST);

  // Search runs from the far end so the nearest requester overwrites earlier hits.
  always_comb begin
    int idx;
    idx = 0;
    win = '0;
    for (int k = N_MASTERS - 1; k >= 0; k--) begin
      idx = (PRIORITY_MODE == 1) ? k : (int'(ptr_q) + k) % N_MASTERS;
      if (req[idx]) win = OW'(idx);
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    err_d   = '0;
    if (free) begin
      cnt_d = '0;
      if (|req) begin
        state_d      = OWN;
        owner_d      = win;
        grant_d      = '0;
        grant_d[win] = 1'b1;
        if (PRIORITY_MODE == 0) ptr_d = nxt(win);
      end else begin
        state_d = IDLE;
        grant_d = '0;
      end
    end else if (timeout) begin
      // Drop the stalled owner and let arbitration resume at the next free edge.
      state_d        = IDLE;
      grant_d        = '0;
      cnt_d          = '0;
      err_d[owner_q] = 1'b1;
      if (PRIORITY_MODE == 0) ptr_d = nxt(owner_q);
    end else if (bus.s_ack_i) begin
      cnt_d = '0;
    end else if (bus.s_stb_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      owner_q <= '0;
      grant_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    bus.s_cyc_o = 1'b0;
    bus.s_stb_o = 1'b0;
    bus.s_we_o  = 1'b0;
    bus.s_sel_o = '0;
    bus.s_adr_o = '0;
    bus.s_dat_o = '0;
    if (state_q == OWN) begin
      bus.s_cyc_o = bus.m_cyc_i[owner_q];
      bus.s_stb_o = bus.m_stb_i[owner_q];
      bus.s_we_o  = bus.m_we_i[owner_q];
      bus.s_sel_o = bus.m_sel_i[owner_q*SW +: SW];
      bus.s_adr_o = bus.m_adr_i[owner_q*AW +: AW];
      bus.s_dat_o = bus.m_dat_i[owner_q*DW +: DW];
    end
  end

  assign bus.m_ack_o = {N_MASTERS{bus.s_ack_i}} & grant_q;
  assign bus.m_err_o = err_q;
  assign bus.m_dat_o = bus.s_dat_i;
  assign grant_o     = grant_q;
  assign busy_o      = |grant_q;
endmodule

// File: tb/tb_wb_arbiter_nm.sv
// Bench for wb_arbiter_nm: round-robin and fixed-priority instances share one stimulus stream
// and are compared every cycle against an owner/pointer/counter reference model.
module tb_wb_arbiter_nm;
  localparam int N = 4, AW = 32, DW = 32, SW = 4, TO = 8;

  logic clk = 1'b0, rst;
  always #5 clk = ~clk;

  logic [N-1:0]    cyc, stb, we;
  logic [N*SW-1:0] sel;
  logic [N*AW-1:0] adr;
  logic [N*DW-1:0] dat;
  logic            ack;
  logic [DW-1:0]   sdat;
  logic [N-1:0]    grant0, grant1;
  logic            busy0, busy1;
  int checks = 0, errors = 0;

  wb_arbiter_nm_if #(.N_MASTERS(N), .AW(AW), .DW(DW)) bus0 ();
  wb_arbiter_nm_if #(.N_MASTERS(N), .AW(AW), .DW(DW)) bus1 ();

  assign bus0.m_cyc_i = cyc;  assign bus1.m_cyc_i = cyc;
  assign bus0.m_stb_i = stb;  assign bus1.m_stb_i = stb;
  assign bus0.m_we_i  = we;   assign bus1.m_we_i  = we;
  assign bus0.m_sel_i = sel;  assign bus1.m_sel_i = sel;
  assign bus0.m_adr_i = adr;  assign bus1.m_adr_i = adr;
  assign bus0.m_dat_i = dat;  assign bus1.m_dat_i = dat;
  assign bus0.s_ack_i = ack;  assign bus1.s_ack_i = ack;
  assign bus0.s_dat_i = sdat; assign bus1.s_dat_i = sdat;

  wb_arbiter_nm #(.N_MASTERS(N), .AW(AW), .DW(DW), .PRIORITY_MODE(0), .TIMEOUT(TO)) u_rr (
    .wb_clk_i(clk), .wb_rst_i(rst), .bus(bus0), .grant_o(grant0), .busy_o(busy0));
  wb_arbiter_nm #(.N_MASTERS(N), .AW(AW), .DW(DW), .PRIORITY_MODE(1), .TIMEOUT(TO)) u_fx (
    .wb_clk_i(clk), .wb_rst_i(rst), .bus(bus1), .grant_o(grant1), .busy_o(busy1));

  // Model state per instance (0 = round-robin, 1 = fixed): owner index or -1 when free.
  int           m_own[2], m_p[2], m_cnt[2];
  logic [N-1:0] m_err[2];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_step(input int d);
    int  w, o;
    bit  free, to;
    if (rst) begin
      m_own[d] = -1; m_p[d] = 0; m_cnt[d] = 0; m_err[d] = '0;
      return;
    end
    o = m_own[d];
    m_err[d] = '0;
    free = (o < 0) || !cyc[o];
    to   = !free && stb[o] && !ack && (m_cnt[d] + 1 == TO);
    if (free) begin
      w = -1;
      for (int k = 0; k < N; k++) begin
        int i;
        i = (d == 0) ? (m_p[d] + k) % N : k;
        if (w < 0 && cyc[i] && stb[i]) w = i;
      end
      m_own[d] = w;
      m_cnt[d] = 0;
      if (w >= 0 && d == 0) m_p[d] = (w + 1) % N;
    end else if (to) begin
      m_err[d][o] = 1'b1;
      if (d == 0) m_p[d] = (o + 1) % N;
      m_own[d] = -1;
      m_cnt[d] = 0;
    end else if (ack) m_cnt[d] = 0;
    else if (stb[o]) m_cnt[d]++;
  endtask

  task automatic check_dut(input int d, input logic [N-1:0] g, input logic b,
                           input logic [N-1:0] a, input logic [N-1:0] e,
                           input logic sc, input logic ss, input logic sw,
                           input logic [SW-1:0] ssel, input logic [AW-1:0] sadr,
                           input logic [DW-1:0] sd, input logic [DW-1:0] md);
    int o;
    string p;
    logic [N-1:0] eg;
    o  = m_own[d];
    p  = (d == 0) ? "rr" : "fx";
    eg = '0;
    if (o >= 0) eg[o] = 1'b1;
    chk({p, " grant"}, g, eg);
    chk({p, " busy"}, b, o >= 0);
    chk({p, " ack"}, a, ack ? eg : '0);
    chk({p, " err"}, e, m_err[d]);
    chk({p, " s_cyc"}, sc, (o >= 0) ? cyc[o] : 1'b0);
    chk({p, " s_stb"}, ss, (o >= 0) ? stb[o] : 1'b0);
    chk({p, " s_we"}, sw, (o >= 0) ? we[o] : 1'b0);
    chk({p, " s_sel"}, ssel, (o >= 0) ? sel[o*SW +: SW] : '0);
    chk({p, " s_adr"}, sadr, (o >= 0) ? adr[o*AW +: AW] : '0);
    chk({p, " s_dat"}, sd, (o >= 0) ? dat[o*DW +: DW] : '0);
    chk({p, " m_dat"}, md, sdat);
  endtask

  task automatic tick;
    @(negedge clk);
    check_dut(0, grant0, busy0, bus0.m_ack_o, bus0.m_err_o, bus0.s_cyc_o, bus0.s_stb_o,
              bus0.s_we_o, bus0.s_sel_o, bus0.s_adr_o, bus0.s_dat_o, bus0.m_dat_o);
    check_dut(1, grant1, busy1, bus1.m_ack_o, bus1.m_err_o, bus1.s_cyc_o, bus1.s_stb_o,
              bus1.s_we_o, bus1.s_sel_o, bus1.s_adr_o, bus1.s_dat_o, bus1.m_dat_o);
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
  endtask

  task automatic clr;
    cyc = '0; stb = '0; we = '0; sel = '0; adr = '0; dat = '0; ack = 1'b0; sdat = '0;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick;
    rst = 1'b0;
  endtask

  initial begin
    int seq[6] = '{0, 1, 3, 0, 1, 3};
    int stall = 0;
    logic [N-1:0] one = 1;

    clr;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    tick;
    chk("rst grant", grant0, '0);
    chk("rst s_cyc", bus0.s_cyc_o, 1'b0);
    rst = 1'b0;

    // single master 2 write
    cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b1; sel[2*SW +: SW] = 4'hF;
    adr[2*AW +: AW] = 32'h3000_0010; dat[2*DW +: DW] = 32'hDEAD_BEEF;
    tick;
    chk("m2 grant", grant0, 4'b0100);
    chk("m2 s_adr", bus0.s_adr_o, 32'h3000_0010);
    chk("m2 s_dat", bus0.s_dat_o, 32'hDEAD_BEEF);
    ack = 1'b1;
    #1;
    chk("m2 ack", bus0.m_ack_o, 4'b0100);
    tick;
    clr;
    tick;
    ack = 1'b1;
    #1;
    chk("idle ack", bus0.m_ack_o, '0);
    tick;

    // round-robin fairness with one-beat cycles
    clr;
    do_reset;
    cyc = 4'b1011; stb = 4'b1011;
    tick;
    for (int k = 0; k < 6; k++) begin
      chk("rr seq", grant0, one << seq[k]);
      ack = 1'b1;
      tick;
      ack = 1'b0; cyc[seq[k]] = 1'b0; stb[seq[k]] = 1'b0;
      tick;
      cyc[seq[k]] = 1'b1; stb[seq[k]] = 1'b1;
    end

    // block lock then zero-gap handoff
    clr;
    do_reset;
    cyc[1] = 1'b1; stb[1] = 1'b1;
    tick;
    cyc[0] = 1'b1; stb[0] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      ack = 1'b1;
      tick;
      chk("lock grant", grant0, 4'b0010);
    end
    ack = 1'b0; cyc[1] = 1'b0; stb[1] = 1'b0;
    tick;
    chk("handoff", grant0, 4'b0001);

    // reset mid-burst with a pending ack, then {2,0} request after reset
    cyc = 4'b0101; stb = 4'b0101; ack = 1'b1;
    rst = 1'b1;
    tick;
    chk("rst mid grant", grant0, '0);
    chk("rst mid s_cyc", bus0.s_cyc_o, 1'b0);
    chk("rst mid ack", bus0.m_ack_o, '0);
    rst = 1'b0; ack = 1'b0;
    tick;
    chk("post rst win", grant0, 4'b0001);

    // ack timeout on master 3
    clr;
    do_reset;
    cyc[3] = 1'b1; stb[3] = 1'b1;
    tick;
    chk("to grant", grant0, 4'b1000);
    for (int k = 0; k < TO - 1; k++) begin
      tick;
      chk("to hold", grant0, 4'b1000);
    end
    tick;
    chk("to err", bus0.m_err_o, 4'b1000);
    chk("to drop", grant0, '0);
    chk("to s_cyc", bus0.s_cyc_o, 1'b0);
    cyc = '0; stb = '0; ack = 1'b1;
    #1;
    chk("to late ack", bus0.m_ack_o, '0);
    tick;
    chk("to err pulse", bus0.m_err_o, '0);

    // randomized traffic, long-holding masters and stall bursts to provoke timeouts
    clr;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(15) == 0) cyc[i] = ~cyc[i];
        stb[i] = cyc[i] ? ($urandom_range(3) != 0) : ($urandom_range(7) == 0);
        we[i]  = 1'($urandom);
        sel[i*SW +: SW] = 4'($urandom);
        adr[i*AW +: AW] = $urandom;
        dat[i*DW +: DW] = $urandom;
      end
      if (stall == 0 && $urandom_range(40) == 0) stall = 20;
      if (stall > 0) begin
        ack = 1'b0;
        stall--;
      end else ack = ($urandom_range(2) == 0);
      sdat = $urandom;
      rst  = ($urandom_range(399) == 0);
      tick;
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/wb_arbiter_nm.md
# wb_arbiter_nm

Parametrised N-master Wishbone bus arbiter that sits between the bus masters (CPU, DMA engines, accelerators) and the single shared user-project Wishbone slave port. It generalises the two-master, DMA-first arbitration to N masters with selectable round-robin or fixed priority, holds ownership for a whole Wishbone cycle (block transfers), and adds a per-transaction ack timeout with an error response. Grant is registered; the slave-side bus is a registered-select mux of the owner's signals.

## Interface
- N_MASTERS, 4: number of masters, 2..8.
- AW, 32: address width.
- DW, 32: data width, multiple of 8; SW = DW/8.
- PRIORITY_MODE, 0: 0 = round-robin, 1 = fixed (index 0 highest).
- TIMEOUT, 255: stalled cycles before error; 0 disables timeout.

- wb_clk_i  in  1  clock; all logic on rising edge.
- wb_rst_i  in  1  synchronous, active-high reset.
- m_cyc_i  in  N_MASTERS  per-master cycle.
- m_stb_i  in  N_MASTERS  per-master strobe.
- m_we_i  in  N_MASTERS  per-master write enable.
- m_sel_i  in  N_MASTERS*SW  byte selects, master i at [i*SW +: SW].
- m_adr_i  in  N_MASTERS*AW  addresses, packed likewise.
- m_dat_i  in  N_MASTERS*DW  write data, packed likewise.
- m_ack_o  out  N_MASTERS  ack, only to owner.
- m_err_o  out  N_MASTERS  one-cycle timeout error, only to owner.
- m_dat_o  out  DW  read data, s_dat_i broadcast to all masters.
- s_cyc_o, s_stb_o, s_we_o  out  1 each  slave-side controls.
- s_sel_o  out  SW; s_adr_o  out  AW; s_dat_o  out  DW  slave-side payload.
- s_ack_i  in  1  slave ack.  s_dat_i  in  DW  slave read data.
- grant_o  out  N_MASTERS  registered one-hot owner, all-zero when free.
- busy_o  out  1  OR of grant_o.

## Operation
- Request of master i: req[i] = m_cyc_i[i] & m_stb_i[i].
- States: IDLE (grant_o = 0) and OWN (one-hot grant_o).
- Bus free at an edge when in IDLE, or in OWN with m_cyc_i[owner] = 0. At a free edge: if any req, grant winner (enter/stay OWN); else go IDLE.
- Round-robin: pointer p (reset 0); winner = first i with req[i] searching p, p+1, ... mod N_MASTERS; on grant p <= (winner+1) mod N_MASTERS. Fixed: winner = lowest set index; p unused.
- In OWN the owner keeps the bus while its m_cyc_i stays high, across any number of stb/ack beats; other requests wait.
- Slave outputs: when OWN, s_cyc_o/s_stb_o/s_we_o/s_sel_o/s_adr_o/s_dat_o = owner's inputs (combinational through registered select); when IDLE all zero.
- m_ack_o[i] = s_ack_i & grant_o[i]. s_ack_i in IDLE is ignored.
- Timeout (TIMEOUT > 0): counter cnt cleared on grant and on every s_ack_i; increments each OWN cycle with s_stb_o = 1 and s_ack_i = 0. At the edge where cnt would reach TIMEOUT: m_err_o[owner] registered high for exactly one cycle, grant dropped (IDLE), round-robin pointer advances past owner, no winner chosen at that edge. Width of cnt: clog2(TIMEOUT+1).
- Reset values: grant_o = 0, busy_o = 0, m_err_o = 0, p = 0, cnt = 0, state IDLE; hence s_cyc_o = s_stb_o = 0 and m_ack_o = 0.

## Timing
- Grant latency: req asserted before edge k, bus free -> grant_o/s_cyc_o valid in cycle after edge k (1 cycle).
- Handoff: owner drops m_cyc_i before edge k with another req pending -> new owner granted after edge k; zero dead cycles.
- Ack is combinational to owner, same cycle as s_ack_i.
- Timeout: stb with no ack for TIMEOUT consecutive cycles -> m_err_o pulse in following cycle, s_cyc_o low that same cycle.
- Reset mid-transfer: at reset edge grant_o, slave controls, err clear immediately; pending ack discarded.
- Simultaneous owner-release and timeout edge: release wins, no error.

## Test plan
- Single master 2 write: m_cyc/stb[2]=1, adr 0x3000_0010, dat 0xDEADBEEF -> grant_o=4'b0100 one cycle later, s_adr_o=0x3000_0010, ack to m_ack_o[2] only.
- Round-robin fairness: masters 0,1,3 request continuously, 1-beat cycles -> grant sequence 0,1,3,0,1,3; fixed mode -> always 0.
- Block lock: master 1 holds cyc for 4 beats while master 0 requests -> grant stays 4'b0010 for all 4 acks, switches to 4'b0001 at release edge with no idle cycle.
- Timeout: TIMEOUT=8, slave never acks master 3 -> m_err_o[3] one-cycle pulse after 8 stall cycles, grant_o=0, later s_ack_i ignored.
- Reset during OWN: assert wb_rst_i mid-burst -> next cycle grant_o=0, s_cyc_o=0, p=0; first post-reset request by master 2 of {2,0} wins 0 in round-robin.
- Idle ack: s_ack_i=1 with no owner -> all m_ack_o stay 0.
